// File: rtl/bp_cache_req_mux.sv
// bp_cache_req_mux: arbitrates N cache-engine request channels onto a single LCE request port.
// Define BP_CACHE_REQ_MUX_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module bp_cache_req_mux
  #(parameter int channels_p       = 2
  , parameter int req_width_p      = 64
  , parameter int metadata_width_p = 4
  )
  (input  logic                                     clk_i
  , input  logic                                    reset_n_i
  , input  logic [channels_p*req_width_p-1:0]       cache_req_i
  , input  logic [channels_p-1:0]                   cache_req_v_i
  , output logic [channels_p-1:0]                   cache_req_ready_o
  , input  logic [channels_p*metadata_width_p-1:0]  cache_req_metadata_i
  , input  logic [channels_p-1:0]                   cache_req_metadata_v_i
  , output logic [channels_p-1:0]                   cache_req_complete_o
  , output logic [req_width_p-1:0]                  lce_req_o
  , output logic                                    lce_req_v_o
  , input  logic                                    lce_req_ready_i
  , output logic [metadata_width_p-1:0]             lce_req_metadata_o
  , output logic                                    lce_req_metadata_v_o
  , input  logic                                    lce_req_complete_i
  , output logic [$clog2(channels_p)-1:0]           owner_o
  , output logic                                    busy_o
  , output logic                                    err_o
  );

  localparam int lg_channels_lp = $clog2(channels_p);

  typedef logic [lg_channels_lp-1:0] chan_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_META,
    BUSY
  } state_e;

  state_e    state_r;
  chan_idx_t owner_r;
  logic      busy_r;
  logic      err_r;

  logic [req_width_p-1:0]      req_a  [channels_p];
  logic [metadata_width_p-1:0] meta_a [channels_p];

  for (genvar g = 0; g < channels_p; g++) begin : g_unpack
    assign req_a[g]  = cache_req_i[g*req_width_p +: req_width_p];
    assign meta_a[g] = cache_req_metadata_i[g*metadata_width_p +: metadata_width_p];
  end

`ifdef BP_CACHE_REQ_MUX_RR_EN
  chan_idx_t last_grant_r;
`endif

  logic      grant_v;
  chan_idx_t grant_idx;

  // Search begins one past the last granted channel in round-robin mode, at channel 0 otherwise.
  always_comb begin
    int start;
    int cand;
    start     = 0;
    cand      = 0;
    grant_v   = 1'b0;
    grant_idx = '0;
`ifdef BP_CACHE_REQ_MUX_RR_EN
    start = int'(last_grant_r) + 1;
`endif
    for (int i = 0; i < channels_p; i++) begin
      cand = (start + i) % channels_p;
      if (!grant_v && cache_req_v_i[chan_idx_t'(cand)]) begin
        grant_v   = 1'b1;
        grant_idx = chan_idx_t'(cand);
      end
    end
  end

  logic                  accept;
  logic                  meta_now;
  logic                  meta_wait;
  logic                  meta_fwd;
  logic                  complete_fwd;
  logic                  err_set;
  chan_idx_t             meta_src;
  logic [channels_p-1:0] grant_oh;
  logic [channels_p-1:0] owner_oh;

  assign grant_oh = channels_p'(1) << grant_idx;
  assign owner_oh = channels_p'(1) << owner_r;

  // Every forwarding path is qualified by reset_n_i so outputs drop to zero as soon as reset asserts.
  assign accept       = reset_n_i & (state_r == IDLE) & grant_v & lce_req_ready_i;
  assign meta_now     = accept & cache_req_metadata_v_i[grant_idx];
  assign meta_wait    = reset_n_i & (state_r == WAIT_META)
                      & cache_req_metadata_v_i[owner_r] & ~lce_req_complete_i;
  assign meta_fwd     = meta_now | meta_wait;
  assign meta_src     = accept ? grant_idx : owner_r;
  assign complete_fwd = reset_n_i & lce_req_complete_i & (state_r != IDLE);

  assign err_set = ((state_r == IDLE)      & lce_req_complete_i)
                 | ((state_r == WAIT_META) & (lce_req_complete_i
                                              | (|(cache_req_metadata_v_i & ~owner_oh))))
                 | ((state_r == BUSY)      & (|cache_req_metadata_v_i));

  assign cache_req_ready_o    = accept ? grant_oh : '0;
  assign lce_req_v_o          = accept;
  assign lce_req_o            = accept ? req_a[grant_idx] : '0;
  assign lce_req_metadata_v_o = meta_fwd;
  assign lce_req_metadata_o   = meta_fwd ? meta_a[meta_src] : '0;
  assign cache_req_complete_o = complete_fwd ? owner_oh : '0;
  assign owner_o              = owner_r;
  assign busy_o               = busy_r;
  assign err_o                = err_r;

  // A completion that arrives before metadata still closes the transaction, skipping forwarding.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      owner_r      <= '0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
`ifdef BP_CACHE_REQ_MUX_RR_EN
      last_grant_r <= chan_idx_t'(channels_p - 1);
`endif
    end else begin
      if (err_set) begin
        err_r <= 1'b1;
      end
      unique case (state_r)
        IDLE: begin
          if (accept) begin
            owner_r <= grant_idx;
            busy_r  <= 1'b1;
            state_r <= meta_now ? BUSY : WAIT_META;
`ifdef BP_CACHE_REQ_MUX_RR_EN
            last_grant_r <= grant_idx;
`endif
          end
        end
        WAIT_META: begin
          if (lce_req_complete_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (cache_req_metadata_v_i[owner_r]) begin
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (lce_req_complete_i) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cache_req_mux.sv
// tb_bp_cache_req_mux: directed scoreboard bench for a 3-channel bp_cache_req_mux.
// Stimulus pushes expected LCE requests, metadata and completions; a negedge monitor pops and compares.
module tb_bp_cache_req_mux;

  localparam int ch_lp   = 3;
  localparam int rw_lp   = 64;
  localparam int mw_lp   = 4;

  logic                    clk_i;
  logic                    reset_n_i;
  logic [ch_lp*rw_lp-1:0]  cache_req_i;
  logic [ch_lp-1:0]        cache_req_v_i;
  logic [ch_lp-1:0]        cache_req_ready_o;
  logic [ch_lp*mw_lp-1:0]  cache_req_metadata_i;
  logic [ch_lp-1:0]        cache_req_metadata_v_i;
  logic [ch_lp-1:0]        cache_req_complete_o;
  logic [rw_lp-1:0]        lce_req_o;
  logic                    lce_req_v_o;
  logic                    lce_req_ready_i;
  logic [mw_lp-1:0]        lce_req_metadata_o;
  logic                    lce_req_metadata_v_o;
  logic                    lce_req_complete_i;
  logic [1:0]              owner_o;
  logic                    busy_o;
  logic                    err_o;

  bp_cache_req_mux #(
    .channels_p      (ch_lp),
    .req_width_p     (rw_lp),
    .metadata_width_p(mw_lp)
  ) dut (
    .clk_i                 (clk_i),
    .reset_n_i             (reset_n_i),
    .cache_req_i           (cache_req_i),
    .cache_req_v_i         (cache_req_v_i),
    .cache_req_ready_o     (cache_req_ready_o),
    .cache_req_metadata_i  (cache_req_metadata_i),
    .cache_req_metadata_v_i(cache_req_metadata_v_i),
    .cache_req_complete_o  (cache_req_complete_o),
    .lce_req_o             (lce_req_o),
    .lce_req_v_o           (lce_req_v_o),
    .lce_req_ready_i       (lce_req_ready_i),
    .lce_req_metadata_o    (lce_req_metadata_o),
    .lce_req_metadata_v_o  (lce_req_metadata_v_o),
    .lce_req_complete_i    (lce_req_complete_i),
    .owner_o               (owner_o),
    .busy_o                (busy_o),
    .err_o                 (err_o)
  );

  typedef struct {
    logic [ch_lp-1:0] oh;
    logic [rw_lp-1:0] data;
  } exp_req_t;

  exp_req_t         exp_req_q  [$];
  logic [mw_lp-1:0] exp_meta_q [$];
  logic [ch_lp-1:0] exp_cpl_q  [$];

  int checks = 0;
  int errors = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, then drive the control inputs for that cycle.
  task automatic applyStimulus(input logic [ch_lp-1:0] v, input logic rdy,
                               input logic [ch_lp-1:0] mv, input logic cpl);
    @(posedge clk_i);
    #1;
    cache_req_v_i          = v;
    lce_req_ready_i        = rdy;
    cache_req_metadata_v_i = mv;
    lce_req_complete_i     = cpl;
  endtask

  task automatic set_req(input int ch, input logic [rw_lp-1:0] d);
    cache_req_i[ch*rw_lp +: rw_lp] = d;
  endtask

  task automatic set_meta(input int ch, input logic [mw_lp-1:0] m);
    cache_req_metadata_i[ch*mw_lp +: mw_lp] = m;
  endtask

  task automatic expect_req(input int ch, input logic [rw_lp-1:0] d);
    exp_req_t e;
    e.oh   = 3'b001 << ch;
    e.data = d;
    exp_req_q.push_back(e);
  endtask

  task automatic expect_meta(input logic [mw_lp-1:0] m);
    exp_meta_q.push_back(m);
  endtask

  task automatic expect_cpl(input int ch);
    logic [ch_lp-1:0] oh;
    oh = 3'b001 << ch;
    exp_cpl_q.push_back(oh);
  endtask

  // Monitor: any presented output must match the head of its expectation queue.
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (lce_req_v_o) begin
        if (exp_req_q.size() == 0) begin
          checkOutput("unexpected_lce_req", {63'd0, lce_req_v_o}, 64'd0);
        end else begin
          exp_req_t e;
          e = exp_req_q.pop_front();
          checkOutput("req_ready_onehot", {61'd0, cache_req_ready_o}, {61'd0, e.oh});
          checkOutput("req_data", lce_req_o, e.data);
        end
      end else begin
        checkOutput("ready_without_req", {61'd0, cache_req_ready_o}, 64'd0);
      end
      if (lce_req_metadata_v_o) begin
        if (exp_meta_q.size() == 0) begin
          checkOutput("unexpected_meta", {60'd0, lce_req_metadata_o}, 64'hdead);
        end else begin
          logic [mw_lp-1:0] m;
          m = exp_meta_q.pop_front();
          checkOutput("meta_data", {60'd0, lce_req_metadata_o}, {60'd0, m});
        end
      end
      if (cache_req_complete_o != '0) begin
        if (exp_cpl_q.size() == 0) begin
          checkOutput("unexpected_complete", {61'd0, cache_req_complete_o}, 64'd0);
        end else begin
          logic [ch_lp-1:0] c;
          c = exp_cpl_q.pop_front();
          checkOutput("complete_route", {61'd0, cache_req_complete_o}, {61'd0, c});
        end
      end
    end
  end

  initial begin
    int busy_cnt;
    int exp_ch;
    reset_n_i              = 1'b0;
    cache_req_i            = '0;
    cache_req_v_i          = '0;
    cache_req_metadata_i   = '0;
    cache_req_metadata_v_i = '0;
    lce_req_ready_i        = 1'b0;
    lce_req_complete_i     = 1'b0;

    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("reset_busy", {63'd0, busy_o}, 64'd0);
    checkOutput("reset_err", {63'd0, err_o}, 64'd0);
    checkOutput("reset_owner", {62'd0, owner_o}, 64'd0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    reset_n_i = 1'b1;

    // Single transaction on channel 1: metadata two cycles after accept, completion four after that.
    busy_cnt = 0;
    set_req(1, 64'hABCD);
    set_meta(1, 4'h3);
    for (int cyc = 0; cyc < 9; cyc++) begin
      case (cyc)
        0: begin applyStimulus(3'b010, 1'b1, 3'b000, 1'b0); expect_req(1, 64'hABCD); end
        2: begin applyStimulus(3'b000, 1'b1, 3'b010, 1'b0); expect_meta(4'h3); end
        6: begin applyStimulus(3'b000, 1'b1, 3'b000, 1'b1); expect_cpl(1); end
        default: applyStimulus(3'b000, 1'b1, 3'b000, 1'b0);
      endcase
      #1;
      if (busy_o) busy_cnt++;
      if (cyc == 3) checkOutput("t1_owner", {62'd0, owner_o}, 64'd1);
    end
    checkOutput("t1_busy_cycles", busy_cnt, 64'd6);

    // Contention: channels 0 and 1 request continuously for four transactions.
    set_req(0, 64'h1000_0000);
    set_req(1, 64'h2000_0000);
    set_meta(0, 4'h1);
    set_meta(1, 4'h2);
    for (int t = 0; t < 4; t++) begin
`ifdef BP_CACHE_REQ_MUX_RR_EN
      exp_ch = t % 2;
`else
      exp_ch = 0;
`endif
      applyStimulus(3'b011, 1'b1, 3'b000, 1'b0);
      expect_req(exp_ch, (exp_ch == 0) ? 64'h1000_0000 : 64'h2000_0000);
      applyStimulus(3'b011, 1'b1, 3'b001 << exp_ch, 1'b0);
      expect_meta(4'(exp_ch + 1));
      applyStimulus(3'b011, 1'b1, 3'b000, 1'b1);
      expect_cpl(exp_ch);
    end

    // Back-pressure: channel 0 waits three cycles with the LCE not ready.
    set_req(0, 64'h5555);
    set_meta(0, 4'h5);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(3'b001, 1'b0, 3'b000, 1'b0);
      #1;
      checkOutput("bp_ready_low", {61'd0, cache_req_ready_o}, 64'd0);
      checkOutput("bp_idle", {63'd0, busy_o}, 64'd0);
    end
    applyStimulus(3'b001, 1'b1, 3'b000, 1'b0);
    expect_req(0, 64'h5555);
    applyStimulus(3'b000, 1'b0, 3'b001, 1'b0);
    expect_meta(4'h5);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1);
    expect_cpl(0);

    // Same-cycle metadata: accept goes straight to BUSY, so a following completion is legal.
    set_req(2, 64'h9999_0000_1234_5678);
    set_meta(2, 4'h9);
    applyStimulus(3'b100, 1'b1, 3'b100, 1'b0);
    expect_req(2, 64'h9999_0000_1234_5678);
    expect_meta(4'h9);
    #1;
    checkOutput("same_cycle_both_valid", {62'd0, lce_req_v_o, lce_req_metadata_v_o}, 64'd3);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1);
    expect_cpl(2);
    #1;
    checkOutput("same_cycle_busy", {63'd0, busy_o}, 64'd1);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("no_err_so_far", {63'd0, err_o}, 64'd0);
    checkOutput("idle_after_cpl", {63'd0, busy_o}, 64'd0);

    // Completion while idle is dropped and flags an error.
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("idle_cpl_err", {63'd0, err_o}, 64'd1);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("err_sticky", {63'd0, err_o}, 64'd1);

    // Reset during BUSY: outputs vanish at once and arbitration restarts at channel 0.
    set_req(0, 64'h7777);
    set_meta(0, 4'h7);
    applyStimulus(3'b001, 1'b1, 3'b001, 1'b0);
    expect_req(0, 64'h7777);
    expect_meta(4'h7);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("pre_reset_busy", {63'd0, busy_o}, 64'd1);
    @(posedge clk_i);
    #1;
    reset_n_i              = 1'b0;
    cache_req_v_i          = 3'b111;
    lce_req_ready_i        = 1'b1;
    cache_req_metadata_v_i = 3'b111;
    lce_req_complete_i     = 1'b1;
    #1;
    checkOutput("reset_all_zero",
                {cache_req_ready_o, lce_req_v_o, lce_req_metadata_v_o, cache_req_complete_o,
                 owner_o, busy_o, err_o, lce_req_metadata_o},
                64'd0);
    checkOutput("reset_req_zero", lce_req_o, 64'd0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    reset_n_i = 1'b1;
    set_req(0, 64'hA0);
    set_req(1, 64'hA1);
    set_req(2, 64'hA2);
    applyStimulus(3'b111, 1'b1, 3'b000, 1'b0);
    expect_req(0, 64'hA0);
    applyStimulus(3'b000, 1'b0, 3'b001, 1'b0);
    expect_meta(4'h7);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1);
    expect_cpl(0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("err_cleared_by_reset", {63'd0, err_o}, 64'd0);

    // Non-owner metadata is dropped and flags an error; completion reaches only the owner.
    set_req(1, 64'hBEEF);
    set_meta(0, 4'h1);
    set_meta(1, 4'hC);
    applyStimulus(3'b010, 1'b1, 3'b000, 1'b0);
    expect_req(1, 64'hBEEF);
    applyStimulus(3'b000, 1'b0, 3'b001, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b010, 1'b0);
    expect_meta(4'hC);
    #1;
    checkOutput("nonowner_meta_err", {63'd0, err_o}, 64'd1);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1);
    expect_cpl(1);

    // Completion while still waiting for metadata returns to IDLE via the owner.
    set_req(0, 64'h1111);
    applyStimulus(3'b001, 1'b1, 3'b000, 1'b0);
    expect_req(0, 64'h1111);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b1);
    expect_cpl(0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    #1;
    checkOutput("wait_meta_cpl_idle", {63'd0, busy_o}, 64'd0);
    checkOutput("wait_meta_cpl_owner", {62'd0, owner_o}, 64'd0);

    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    checkOutput("req_queue_drained", exp_req_q.size(), 64'd0);
    checkOutput("meta_queue_drained", exp_meta_q.size(), 64'd0);
    checkOutput("cpl_queue_drained", exp_cpl_q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_cache_req_mux.md
# bp_cache_req_mux

N-channel cache-request multiplexer between a core's cache engines (icache, dcache, and any added engines such as a page-table walker or accelerator cache) and a single LCE request port. It arbitrates among channels, forwards the winning request and its later metadata, and holds ownership until the LCE signals completion. It then routes the completion pulse back to the owning channel. It replaces per-channel hard-wired LCE ports and removes per-engine metadata padding logic from core wrappers.

## Interface
- channels_p, 2, number of request channels (≥2)
- req_width_p, 64, cache request packet width
- metadata_width_p, 4, max metadata width; narrower channels drive unused MSBs to zero
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- cache_req_i  in  channels_p×req_width_p  per-channel request packets
- cache_req_v_i  in  channels_p  per-channel request valid
- cache_req_ready_o  out  channels_p  per-channel accept strobe (handshake = v_i & ready_o)
- cache_req_metadata_i  in  channels_p×metadata_width_p  per-channel metadata
- cache_req_metadata_v_i  in  channels_p  per-channel metadata valid
- cache_req_complete_o  out  channels_p  completion pulse routed to the owner
- lce_req_o  out  req_width_p  forwarded request
- lce_req_v_o  out  1  forwarded request valid
- lce_req_ready_i  in  1  LCE can accept a request
- lce_req_metadata_o  out  metadata_width_p  forwarded metadata
- lce_req_metadata_v_o  out  1  forwarded metadata valid
- lce_req_complete_i  in  1  LCE completion pulse
- owner_o  out  clog2(channels_p)  current owning channel
- busy_o  out  1  transaction outstanding
- err_o  out  1  sticky protocol error

## Operation
- States: IDLE, WAIT_META, BUSY.
- IDLE:
  - Arbitrate among asserted cache_req_v_i.
  - If lce_req_ready_i=1, the winner gets cache_req_ready_o[w]=1, lce_req_o=cache_req_i[w], lce_req_v_o=1, and owner is latched to w.
  - Next state is WAIT_META. If cache_req_metadata_v_i[w]=1 in the same cycle, metadata is forwarded immediately and the next state is BUSY.
  - If lce_req_ready_i=0, no ready_o is asserted and no state change occurs.
- WAIT_META:
  - On cache_req_metadata_v_i[owner], drive lce_req_metadata_o from the owner and lce_req_metadata_v_o=1, then go to BUSY.
  - Metadata valid on any non-owner channel is ignored and sets err_o.
- BUSY:
  - On lce_req_complete_i, drive cache_req_complete_o[owner]=1 and go to IDLE.
  - Any metadata_v on any channel sets err_o.
- Complete while in WAIT_META:
  - Still routed to the owner and the state goes to IDLE.
  - err_o is set and metadata is never forwarded.
- Complete while in IDLE: ignored, sets err_o.
- cache_req_ready_o is 0 for every channel outside IDLE; requests are held by their sources.
- busy_o=1 in WAIT_META and BUSY.
- err_o clears only on reset.

## Timing
- Request path is zero-latency combinational: channel valid and LCE ready to lce_req_v_o and ready_o in the same cycle.
- Metadata and completion are forwarded combinationally in their arrival cycle.
- The next grant is possible in the cycle after a completion. Minimum transaction is 2 cycles: accept+metadata, then complete.
- Reset:
  - Asynchronous assert forces IDLE, owner=0, err_o=0 and the RR pointer to channels_p-1.
  - All outputs are 0 while reset_n_i=0, including mid-transaction; the in-flight transaction is abandoned.
  - Deassertion is synchronised externally.
- No combinational path from lce_req_complete_i to cache_req_ready_o in the same cycle; a grant after a completion occurs in the following cycle.

## Configuration
- BP_CACHE_REQ_MUX_RR_EN defined:
  - Round-robin arbitration. Search starts at last_grant+1 modulo channels_p.
  - last_grant updates only on an accepted handshake.
- Undefined: fixed priority, lowest index wins; no pointer state.

## Test plan
- Single channel: ch1 request 0xABCD with lce_req_ready_i=1, metadata 0x3 two cycles later, complete four cycles later → lce_req_v_o pulse with 0xABCD, lce_req_metadata_o=0x3 on the arrival cycle, cache_req_complete_o=2'b10 for one cycle, owner_o=1, busy_o high for 6 cycles.
- Contention with RR_EN: ch0 and ch1 request continuously for 4 transactions → grants 0,1,0,1. Without the macro → grants 0,0,0,0.
- Back-pressure: ch0 valid while lce_req_ready_i=0 for 3 cycles → ready_o stays 0, no state change; accept occurs on the 4th cycle when ready rises.
- Same-cycle metadata: request and metadata in the accept cycle → direct IDLE to BUSY, both valids asserted in that cycle.
- Protocol errors: metadata on non-owner ch0 while ch1 owns, and a separate complete while in IDLE → err_o=1 and sticky; complete routes only to the owner.
- Reset mid-BUSY with channels_p=3: assert reset_n_i=0 during BUSY → all outputs 0 immediately; after release, the first grant goes to ch0 under RR.
